apb4_master_bridge: RTL and testbench

- Converts a simple valid/ready request/response port into APB4 initiator transfers.
- Drives the APB4 setup and access phases toward downstream APB4 slaves, such as the user IP wrapper and the archinfo block.
- Holds one outstanding transfer, buffered internally, with an optional access-phase watchdog.
- Sits between the SoC native bus crossbar and the user/peripheral APB4 segment.

---
 rtl/apb4_master_bridge_if.sv | 55 +++++
 rtl/apb4_master_bridge.sv | 170 +++++++++++++++++
 tb/tb_apb4_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_master_bridge_if.sv
// Request/response port plus APB4 initiator bus for apb4_master_bridge.
// master: bridge view; slave: requester + APB4 target view.
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [3:0]            req_wstrb_i;
  logic [2:0]            req_prot_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  timeout_o;
  logic [ADDR_WIDTH-1:0] apb_paddr_o;
  logic [2:0]            apb_pprot_o;
  logic                  apb_psel_o;
  logic                  apb_penable_o;
  logic                  apb_pwrite_o;
  logic [DATA_WIDTH-1:0] apb_pwdata_o;
  logic [3:0]            apb_pstrb_o;
  logic [DATA_WIDTH-1:0] apb_prdata_i;
  logic                  apb_pready_i;
  logic                  apb_pslverr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i,
    input  req_wdata_i, req_wstrb_i, req_prot_i,
    input  rsp_ready_i,
    input  apb_prdata_i, apb_pready_i, apb_pslverr_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output timeout_o,
    output apb_paddr_o, apb_pprot_o, apb_psel_o,
    output apb_penable_o, apb_pwrite_o,
    output apb_pwdata_o, apb_pstrb_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i,
    output req_wdata_i, req_wstrb_i, req_prot_i,
    output rsp_ready_i,
    output apb_prdata_i, apb_pready_i, apb_pslverr_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  timeout_o,
    input  apb_paddr_o, apb_pprot_o, apb_psel_o,
    input  apb_penable_o, apb_pwrite_o,
    input  apb_pwdata_o, apb_pstrb_o
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// Valid/ready request port to APB4 initiator, one transfer in flight.
// Define APB4_MST_TIMEOUT_EN to enable the access-phase watchdog.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_n_i,
  apb4_master_bridge_if.master bus
);

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("apb4_master_bridge: DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("apb4_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_q, timeout_d;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES);
  localparam int CW   = (CLOG < 8) ? 8 : CLOG;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Next-state and registered-output logic of the transfer FSM
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          paddr_d   = bus.req_addr_i;
          pprot_d   = bus.req_prot_i;
          pwrite_d  = bus.req_we_i;
          pwdata_d  = bus.req_wdata_i;
          pstrb_d   = bus.req_we_i ? bus.req_wstrb_i : 4'b0000;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB4_MST_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (bus.apb_pready_i) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.apb_prdata_i;
          rsp_err_d   = bus.apb_pslverr_i;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef APB4_MST_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef APB4_MST_TIMEOUT_EN
  // Watchdog counter of access-phase wait cycles
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.apb_paddr_o   = paddr_q;
  assign bus.apb_pprot_o   = pprot_q;
  assign bus.apb_psel_o    = psel_q;
  assign bus.apb_penable_o = penable_q;
  assign bus.apb_pwrite_o  = pwrite_q;
  assign bus.apb_pwdata_o  = pwdata_q;
  assign bus.apb_pstrb_o   = pstrb_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed self-checking bench for apb4_master_bridge.
// Watchdog steps run only when APB4_MST_TIMEOUT_EN is defined.
module tb_apb4_master_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb4_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic we,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] p);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_we_i    = we;
    bus.req_wdata_i = d;
    bus.req_wstrb_i = s;
    bus.req_prot_i  = p;
  endtask

  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_addr_i    = '0;
    bus.req_we_i      = 1'b0;
    bus.req_wdata_i   = '0;
    bus.req_wstrb_i   = '0;
    bus.req_prot_i    = '0;
    bus.rsp_ready_i   = 1'b0;
    bus.apb_prdata_i  = '0;
    bus.apb_pready_i  = 1'b0;
    bus.apb_pslverr_i = 1'b0;

    // reset state
    tick();
    tick();
    chk1("rst_psel", bus.apb_psel_o, 1'b0);
    chk1("rst_penable", bus.apb_penable_o, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    chk("rst_paddr", bus.apb_paddr_o, 32'h0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk1("rst_timeout", bus.timeout_o, 1'b0);
    chk1("rst_req_ready", bus.req_ready_o, 1'b1);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    req(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0101, 3'b010);
    bus.apb_pready_i = 1'b1;
    bus.apb_prdata_i = 32'hFFFF_FFFF;
    bus.rsp_ready_i  = 1'b1;
    chk1("wr_req_ready", bus.req_ready_o, 1'b1);
    tick();
    bus.req_valid_i = 1'b0;
    chk1("wr_setup_psel", bus.apb_psel_o, 1'b1);
    chk1("wr_setup_pen", bus.apb_penable_o, 1'b0);
    chk("wr_paddr", bus.apb_paddr_o, 32'h0000_1004);
    chk1("wr_pwrite", bus.apb_pwrite_o, 1'b1);
    chk("wr_pwdata", bus.apb_pwdata_o, 32'hDEAD_BEEF);
    chk("wr_pstrb", {28'd0, bus.apb_pstrb_o}, 32'h5);
    chk("wr_pprot", {29'd0, bus.apb_pprot_o}, 32'h2);
    chk1("wr_busy_ready", bus.req_ready_o, 1'b0);
    tick();
    chk1("wr_acc_psel", bus.apb_psel_o, 1'b1);
    chk1("wr_acc_pen", bus.apb_penable_o, 1'b1);
    chk1("wr_acc_rsp", bus.rsp_valid_o, 1'b0);
    tick();
    chk1("wr_rsp_valid", bus.rsp_valid_o, 1'b1);
    chk("wr_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk1("wr_rsp_err", bus.rsp_err_o, 1'b0);
    chk1("wr_rsp_psel", bus.apb_psel_o, 1'b0);
    chk1("wr_rsp_pen", bus.apb_penable_o, 1'b0);
    tick();
    chk1("wr_done_valid", bus.rsp_valid_o, 1'b0);
    chk1("wr_done_ready", bus.req_ready_o, 1'b1);

    // read with 3 wait states; pslverr in a non-ready cycle
    bus.apb_pready_i = 1'b0;
    bus.apb_prdata_i = 32'h0;
    bus.rsp_ready_i  = 1'b0;
    req(32'h0000_2000, 1'b0, 32'hAAAA_5555, 4'hF, 3'b001);
    tick();
    bus.req_valid_i = 1'b0;
    chk1("rd_pwrite", bus.apb_pwrite_o, 1'b0);
    chk("rd_setup_pstrb", {28'd0, bus.apb_pstrb_o}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.apb_pslverr_i = (i == 1);
      if (i == 3) begin
        bus.apb_pready_i = 1'b1;
        bus.apb_prdata_i = 32'h1234_5678;
      end
      chk1("rd_acc_psel", bus.apb_psel_o, 1'b1);
      chk1("rd_acc_pen", bus.apb_penable_o, 1'b1);
      chk("rd_acc_paddr", bus.apb_paddr_o, 32'h0000_2000);
      chk("rd_acc_pstrb", {28'd0, bus.apb_pstrb_o}, 32'h0);
      chk1("rd_acc_pwrite", bus.apb_pwrite_o, 1'b0);
      chk("rd_acc_pprot", {29'd0, bus.apb_pprot_o}, 32'h1);
      chk1("rd_acc_rsp", bus.rsp_valid_o, 1'b0);
      tick();
    end
    bus.apb_pready_i = 1'b0;
    bus.apb_prdata_i = 32'h0;
    chk1("rd_rsp_valid", bus.rsp_valid_o, 1'b1);
    chk("rd_rsp_rdata", bus.rsp_rdata_o, 32'h1234_5678);
    chk1("rd_rsp_err", bus.rsp_err_o, 1'b0);
    tick();
    chk1("rd_hold_valid", bus.rsp_valid_o, 1'b1);
    chk("rd_hold_rdata", bus.rsp_rdata_o, 32'h1234_5678);
    bus.rsp_ready_i = 1'b1;
    tick();
    chk1("rd_done_valid", bus.rsp_valid_o, 1'b0);

    // slave error on the ready cycle
    req(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'b000);
    bus.apb_pready_i  = 1'b1;
    bus.apb_pslverr_i = 1'b1;
    bus.apb_prdata_i  = 32'hCAFE_0001;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    chk1("err_rsp_valid", bus.rsp_valid_o, 1'b1);
    chk1("err_rsp_err", bus.rsp_err_o, 1'b1);
    chk("err_rsp_rdata", bus.rsp_rdata_o, 32'hCAFE_0001);
    bus.apb_pslverr_i = 1'b0;
    tick();

    // response backpressure with a second request pending
    bus.rsp_ready_i = 1'b0;
    req(32'h0000_4000, 1'b1, 32'h1111_1111, 4'hF, 3'b000);
    tick();
    req(32'h0000_5000, 1'b1, 32'h2222_2222, 4'h3, 3'b100);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_req_ready", bus.req_ready_o, 1'b0);
      chk1("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata_o, 32'h0);
      chk1("bp_rsp_err", bus.rsp_err_o, 1'b0);
      chk1("bp_psel", bus.apb_psel_o, 1'b0);
      chk("bp_paddr", bus.apb_paddr_o, 32'h0000_4000);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    chk1("bp_hs_valid", bus.rsp_valid_o, 1'b0);
    chk1("bp_hs_ready", bus.req_ready_o, 1'b1);
    chk1("bp_hs_psel", bus.apb_psel_o, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    chk1("bp_b_psel", bus.apb_psel_o, 1'b1);
    chk("bp_b_paddr", bus.apb_paddr_o, 32'h0000_5000);
    chk("bp_b_pwdata", bus.apb_pwdata_o, 32'h2222_2222);
    chk("bp_b_pstrb", {28'd0, bus.apb_pstrb_o}, 32'h3);
    tick();
    tick();
    chk1("bp_b_rsp", bus.rsp_valid_o, 1'b1);
    tick();

    // reset during ACCESS
    bus.apb_pready_i = 1'b0;
    req(32'h0000_6000, 1'b1, 32'h3333_3333, 4'hC, 3'b011);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk1("rm_psel", bus.apb_psel_o, 1'b1);
    chk1("rm_pen", bus.apb_penable_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("rm_psel0", bus.apb_psel_o, 1'b0);
    chk1("rm_pen0", bus.apb_penable_o, 1'b0);
    chk("rm_paddr0", bus.apb_paddr_o, 32'h0);
    chk("rm_pwdata0", bus.apb_pwdata_o, 32'h0);
    chk("rm_pstrb0", {28'd0, bus.apb_pstrb_o}, 32'h0);
    chk1("rm_rsp0", bus.rsp_valid_o, 1'b0);
    rst_n = 1'b1;
    bus.apb_pready_i = 1'b1;
    tick();
    chk1("rm_rsp_after", bus.rsp_valid_o, 1'b0);
    chk1("rm_ready_after", bus.req_ready_o, 1'b1);
    bus.apb_pready_i = 1'b0;

`ifdef APB4_MST_TIMEOUT_EN
    // watchdog abort after 4 ACCESS cycles
    bus.rsp_ready_i  = 1'b0;
    bus.apb_prdata_i = 32'h0000_BBBB;
    req(32'h0000_7000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk1("to_acc_psel", bus.apb_psel_o, 1'b1);
      chk1("to_acc_tmo", bus.timeout_o, 1'b0);
      chk1("to_acc_rsp", bus.rsp_valid_o, 1'b0);
      tick();
    end
    chk1("to_psel", bus.apb_psel_o, 1'b0);
    chk1("to_pen", bus.apb_penable_o, 1'b0);
    chk1("to_tmo", bus.timeout_o, 1'b1);
    chk1("to_rsp", bus.rsp_valid_o, 1'b1);
    chk1("to_err", bus.rsp_err_o, 1'b1);
    chk("to_rdata", bus.rsp_rdata_o, 32'h0);
    tick();
    chk1("to_tmo_pulse", bus.timeout_o, 1'b0);
    chk1("to_rsp_hold", bus.rsp_valid_o, 1'b1);
    bus.rsp_ready_i = 1'b1;
    tick();

    // ready on the 4th ACCESS cycle wins
    req(32'h0000_7004, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.apb_pready_i = 1'b1;
        bus.apb_prdata_i = 32'h0000_BEEF;
      end
      tick();
    end
    bus.apb_pready_i = 1'b0;
    chk1("tw_rsp", bus.rsp_valid_o, 1'b1);
    chk1("tw_err", bus.rsp_err_o, 1'b0);
    chk1("tw_tmo", bus.timeout_o, 1'b0);
    chk("tw_rdata", bus.rsp_rdata_o, 32'h0000_BEEF);
    tick();
`else
    // long wait without watchdog: no abort
    bus.rsp_ready_i = 1'b1;
    req(32'h0000_7000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk1("nw_psel", bus.apb_psel_o, 1'b1);
    chk1("nw_rsp", bus.rsp_valid_o, 1'b0);
    chk1("nw_tmo", bus.timeout_o, 1'b0);
    bus.apb_pready_i = 1'b1;
    bus.apb_prdata_i = 32'h0000_BEEF;
    tick();
    bus.apb_pready_i = 1'b0;
    chk1("nw_rsp_done", bus.rsp_valid_o, 1'b1);
    chk("nw_rdata", bus.rsp_rdata_o, 32'h0000_BEEF);
    chk1("nw_tmo_done", bus.timeout_o, 1'b0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
